// File: rtl/lisnoc_router_vc_arbiter.sv
// LISNoC output-port arbiter: one (port, vc) flit per cycle onto the
// shared link, round-robin over ports and VCs with per-VC packet locks.
module lisnoc_router_vc_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5,
  parameter int vchannels       = 2,
  parameter int vc_lock_packet  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [(flit_data_width+flit_type_width)*ports*vchannels-1:0] flit_i,
  input  logic [ports*vchannels-1:0] request_i,
  output logic [ports*vchannels-1:0] read_o,
  output logic [flit_data_width+flit_type_width-1:0] flit_o,
  output logic [vchannels-1:0] valid_o,
  input  logic [vchannels-1:0] ready_i
);

  localparam int fw = flit_data_width + flit_type_width;
  localparam int pw = (ports > 1) ? $clog2(ports) : 1;
  localparam int vw = (vchannels > 1) ? $clog2(vchannels) : 1;
  localparam bit link_lock = (vc_lock_packet != 0);

  localparam logic [flit_type_width-1:0] t_header = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] t_last   = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] t_single = flit_type_width'(3);

  localparam logic [ports-1:0] port_rst = ports'(1) << (ports - 1);
  localparam logic [vchannels-1:0] vc_rst = vchannels'(1) << (vchannels - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } vc_state_t;

  vc_state_t            state_q [vchannels];
  vc_state_t            state_d [vchannels];
  logic [pw-1:0]        lock_q  [vchannels];
  logic [pw-1:0]        lock_d  [vchannels];
  logic [ports-1:0]     plast_q [vchannels];
  logic [ports-1:0]     plast_d [vchannels];
  logic [vchannels-1:0] vlast_q, vlast_d;
  logic                 own_q, own_d;
  logic [vw-1:0]        ownvc_q, ownvc_d;

  logic [vchannels-1:0] elig;
  logic [pw-1:0]        cand_port [vchannels];

  logic                       grant;
  logic [vw-1:0]              gvc;
  logic [pw-1:0]              gport;
  logic [fw-1:0]              gflit;
  logic [flit_type_width-1:0] gtype;

  // Per-VC port candidate: the locked port, or round-robin after last grant
  always_comb begin
    int  li;
    int  j;
    logic found;
    li    = 0;
    j     = 0;
    found = 1'b0;
    for (int v = 0; v < vchannels; v++) begin
      found        = 1'b0;
      cand_port[v] = '0;
      if (state_q[v] == LOCKED) begin
        found        = request_i[v*ports + int'(lock_q[v])];
        cand_port[v] = lock_q[v];
      end else begin
        li = 0;
        for (int p = 0; p < ports; p++) begin
          if (plast_q[v][p]) li = p;
        end
        for (int i = 1; i <= ports; i++) begin
          j = li + i;
          if (j >= ports) j = j - ports;
          if (!found && request_i[v*ports + j]) begin
            found        = 1'b1;
            cand_port[v] = pw'(j);
          end
        end
      end
      elig[v] = found & ready_i[v];
    end
  end

  always_comb begin
    int li;
    int j;
    grant = 1'b0;
    gvc   = '0;
    li    = 0;
    j     = 0;
    if (link_lock && own_q) begin
      grant = elig[ownvc_q];
      gvc   = ownvc_q;
    end else begin
      for (int v = 0; v < vchannels; v++) begin
        if (vlast_q[v]) li = v;
      end
      for (int i = 1; i <= vchannels; i++) begin
        j = li + i;
        if (j >= vchannels) j = j - vchannels;
        if (!grant && elig[j]) begin
          grant = 1'b1;
          gvc   = vw'(j);
        end
      end
    end
    gport = cand_port[gvc];
  end

  always_comb begin
    valid_o = '0;
    read_o  = '0;
    gflit   = '0;
    if (grant) begin
      valid_o[gvc] = 1'b1;
      read_o[int'(gvc)*ports + int'(gport)] = 1'b1;
      gflit = flit_i[(int'(gvc)*ports + int'(gport))*fw +: fw];
    end
  end

  assign flit_o = gflit;
  assign gtype  = gflit[fw-1 -: flit_type_width];

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    plast_d = plast_q;
    vlast_d = vlast_q;
    own_d   = own_q;
    ownvc_d = ownvc_q;
    if (grant) begin
      vlast_d             = '0;
      vlast_d[gvc]        = 1'b1;
      plast_d[gvc]        = '0;
      plast_d[gvc][gport] = 1'b1;
      unique case (state_q[gvc])
        IDLE: begin
          if (gtype == t_header) begin
            state_d[gvc] = LOCKED;
            lock_d[gvc]  = gport;
            if (link_lock) begin
              own_d   = 1'b1;
              ownvc_d = gvc;
            end
          end
        end
        LOCKED: begin
          if (gtype == t_last || gtype == t_single) begin
            state_d[gvc] = IDLE;
            own_d        = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < vchannels; v++) begin
        state_q[v] <= IDLE;
        lock_q[v]  <= '0;
        plast_q[v] <= port_rst;
      end
      vlast_q <= vc_rst;
      own_q   <= 1'b0;
      ownvc_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      plast_q <= plast_d;
      vlast_q <= vlast_d;
      own_q   <= own_d;
      ownvc_q <= ownvc_d;
    end
  end

endmodule

// File: tb/tb_lisnoc_router_vc_arbiter.sv
// Bench for lisnoc_router_vc_arbiter: table of per-cycle vectors for a
// flit-interleaving instance and a packet-locking instance.
module tb_lisnoc_router_vc_arbiter;

  localparam int DW = 32;
  localparam int TW = 2;
  localparam int P  = 5;
  localparam int V  = 2;
  localparam int FW = DW + TW;
  localparam int N  = P * V;

  localparam logic [1:0] PL = 2'd0;
  localparam logic [1:0] HD = 2'd1;
  localparam logic [1:0] LS = 2'd2;
  localparam logic [1:0] SG = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [FW*N-1:0] flit_a, flit_b;
  logic [N-1:0]    req_a, req_b, read_a, read_b;
  logic [V-1:0]    rdy_a, rdy_b, valid_a, valid_b;
  logic [FW-1:0]   fo_a, fo_b;

  always #5 clk = ~clk;

  lisnoc_router_vc_arbiter #(
    .flit_data_width(DW), .flit_type_width(TW),
    .ports(P), .vchannels(V), .vc_lock_packet(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flit_i(flit_a),
    .request_i(req_a), .read_o(read_a), .flit_o(fo_a),
    .valid_o(valid_a), .ready_i(rdy_a)
  );

  lisnoc_router_vc_arbiter #(
    .flit_data_width(DW), .flit_type_width(TW),
    .ports(P), .vchannels(V), .vc_lock_packet(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flit_i(flit_b),
    .request_i(req_b), .read_o(read_b), .flit_o(fo_b),
    .valid_o(valid_b), .ready_i(rdy_b)
  );

  typedef struct {
    logic         sel;
    logic         rst;
    logic [N-1:0] req;
    logic [V-1:0] rdy;
    logic [2*N-1:0] ty;
    logic [V-1:0] ev;
    logic [N-1:0] er;
  } vec_t;

  typedef struct {
    int            id;
    logic          sel;
    logic [V-1:0]  ev;
    logic [N-1:0]  er;
    logic [FW-1:0] ef;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic logic [2*N-1:0] ty(int s, logic [1:0] t);
    logic [2*N-1:0] r;
    r = '0;
    r[2*s +: 2] = t;
    return r;
  endfunction

  task automatic add(input logic sel, input logic rst,
                     input logic [N-1:0] req, input logic [V-1:0] rdy,
                     input logic [2*N-1:0] t, input logic [V-1:0] ev,
                     input logic [N-1:0] er);
    vec_t v;
    v.sel = sel; v.rst = rst; v.req = req; v.rdy = rdy;
    v.ty = t; v.ev = ev; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, exp);
  endtask

  initial begin
    logic [2*N-1:0] ta;
    ta = ty(0, SG) | ty(2, SG) | ty(3, SG);

    // reset state and reset priority
    add(0, 0, 10'h000, 2'b00, '0, 2'b00, 10'h000);
    add(0, 0, 10'h014, 2'b01, ty(2, SG) | ty(4, SG), 2'b01, 10'h004);
    add(0, 0, 10'h01F, 2'b11, ty(0, SG) | ty(1, SG) | ty(2, SG) |
        ty(3, SG) | ty(4, SG), 2'b01, 10'h001);
    add(0, 1, 10'h000, 2'b11, '0, 2'b00, 10'h000);
    // port round robin on VC0
    add(0, 1, 10'h00D, 2'b01, ta, 2'b01, 10'h001);
    add(0, 1, 10'h00D, 2'b01, ta, 2'b01, 10'h004);
    add(0, 1, 10'h00D, 2'b01, ta, 2'b01, 10'h008);
    add(0, 1, 10'h00D, 2'b01, ta, 2'b01, 10'h001);
    // packet lock on VC0 port 1 against port 4
    add(0, 1, 10'h012, 2'b01, ty(1, HD) | ty(4, SG), 2'b01, 10'h002);
    add(0, 1, 10'h012, 2'b01, ty(1, PL) | ty(4, SG), 2'b01, 10'h002);
    add(0, 1, 10'h012, 2'b01, ty(1, LS) | ty(4, SG), 2'b01, 10'h002);
    add(0, 1, 10'h010, 2'b01, ty(4, SG), 2'b01, 10'h010);
    // locked VC1 port 2 stalls on ready while port 3 waits
    add(0, 1, 10'h080, 2'b10, ty(7, HD), 2'b10, 10'h080);
    add(0, 1, 10'h180, 2'b01, ty(7, PL) | ty(8, SG), 2'b00, 10'h000);
    add(0, 1, 10'h180, 2'b01, ty(7, PL) | ty(8, SG), 2'b00, 10'h000);
    add(0, 1, 10'h180, 2'b01, ty(7, PL) | ty(8, SG), 2'b00, 10'h000);
    add(0, 1, 10'h180, 2'b10, ty(7, PL) | ty(8, SG), 2'b10, 10'h080);
    add(0, 1, 10'h180, 2'b10, ty(7, LS) | ty(8, SG), 2'b10, 10'h080);
    add(0, 1, 10'h100, 2'b10, ty(8, SG), 2'b10, 10'h100);
    // reset mid-packet drops the lock
    add(0, 1, 10'h002, 2'b01, ty(1, HD), 2'b01, 10'h002);
    add(0, 0, 10'h003, 2'b01, ty(0, SG) | ty(1, PL), 2'b01, 10'h001);
    add(0, 1, 10'h003, 2'b01, ty(0, SG) | ty(1, PL), 2'b01, 10'h001);
    add(0, 1, 10'h003, 2'b01, ty(0, SG) | ty(1, PL), 2'b01, 10'h002);
    add(0, 0, 10'h000, 2'b00, '0, 2'b00, 10'h000);
    // two VCs, flit interleaving
    add(0, 1, 10'h021, 2'b11, ty(0, HD) | ty(5, HD), 2'b01, 10'h001);
    add(0, 1, 10'h021, 2'b11, ty(0, PL) | ty(5, HD), 2'b10, 10'h020);
    add(0, 1, 10'h021, 2'b11, ty(0, PL) | ty(5, PL), 2'b01, 10'h001);
    add(0, 1, 10'h021, 2'b11, ty(0, LS) | ty(5, PL), 2'b10, 10'h020);
    add(0, 1, 10'h021, 2'b11, ty(0, LS) | ty(5, LS), 2'b01, 10'h001);
    add(0, 1, 10'h020, 2'b11, ty(5, LS), 2'b10, 10'h020);
    // two VCs, link held for a whole packet
    add(1, 1, 10'h021, 2'b11, ty(0, HD) | ty(5, HD), 2'b01, 10'h001);
    add(1, 1, 10'h021, 2'b11, ty(0, PL) | ty(5, HD), 2'b01, 10'h001);
    add(1, 1, 10'h021, 2'b11, ty(0, LS) | ty(5, HD), 2'b01, 10'h001);
    add(1, 1, 10'h020, 2'b11, ty(5, HD), 2'b10, 10'h020);
    add(1, 1, 10'h020, 2'b11, ty(5, PL), 2'b10, 10'h020);
    add(1, 1, 10'h020, 2'b11, ty(5, LS), 2'b10, 10'h020);

    req_a = '0; req_b = '0; rdy_a = '0; rdy_b = '0;
    flit_a = '0; flit_b = '0;

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      exp_t e;
      exp_t g;
      logic [FW*N-1:0] f;
      logic [N-1:0]    rd;
      logic [V-1:0]    vl;
      logic [FW-1:0]   fo;
      v = vecs[k];
      @(posedge clk);
      #1;
      f = '0;
      for (int s = 0; s < N; s++)
        f[s*FW +: FW] = {v.ty[2*s +: 2], DW'(k*16 + s)};
      rst_n = v.rst;
      req_a  = v.sel ? '0 : v.req;
      rdy_a  = v.sel ? '0 : v.rdy;
      flit_a = v.sel ? '0 : f;
      req_b  = v.sel ? v.req : '0;
      rdy_b  = v.sel ? v.rdy : '0;
      flit_b = v.sel ? f : '0;
      e.id = k; e.sel = v.sel; e.ev = v.ev; e.er = v.er; e.ef = '0;
      for (int s = 0; s < N; s++)
        if (v.er[s]) e.ef = {v.ty[2*s +: 2], DW'(k*16 + s)};
      sb.push_back(e);
      @(negedge clk);
      g  = sb.pop_front();
      rd = g.sel ? read_b : read_a;
      vl = g.sel ? valid_b : valid_a;
      fo = g.sel ? fo_b : fo_a;
      check("valid_o", g.id, 64'(vl), 64'(g.ev));
      check("read_o", g.id, 64'(rd), 64'(g.er));
      check("read_onehot", g.id, 64'($onehot0(rd)), 64'd1);
      if (g.ev != '0) check("flit_o", g.id, 64'(fo), 64'(g.ef));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lisnoc_router_vc_arbiter.md
LISNOC_ROUTER_VC_ARBITER -- requirements
Module: lisnoc_router_vc_arbiter

Interface
REQ-001 Parameter flit_data_width, default 32, flit payload width in bits.
REQ-002 Parameter flit_type_width, default 2, flit type field width; the type field occupies the flit MSBs.
REQ-003 Parameter ports, default 5, number of input ports contending for this output port; ports SHALL be at least 1.
REQ-004 Parameter vchannels, default 2, number of virtual channels sharing the physical output link; vchannels SHALL be at least 1.
REQ-005 Parameter vc_lock_packet, default 0; 0 = link interleaves VCs flit by flit, 1 = link stays with one VC from header to last flit.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 flit_i  input  flit_width*ports*vchannels  flit of (port p, vc v) at slice index v*ports+p, where flit_width = flit_data_width+flit_type_width.
REQ-009 request_i  input  ports*vchannels  (port p, vc v) holds a flit for this output; same index mapping.
REQ-010 read_o  output  ports*vchannels  pop strobe to (port p, vc v); same index mapping.
REQ-011 flit_o  output  flit_width  selected flit.
REQ-012 valid_o  output  vchannels  one-hot VC tag of flit_o; all-zero means no flit.
REQ-013 ready_i  input  vchannels  downstream VC v can accept a flit this cycle.

Function
REQ-014 Type encoding SHALL be PAYLOAD=0, HEADER=1, LAST=2, SINGLE=3.
REQ-015 Output path SHALL be combinational: valid_o, flit_o and read_o depend on the current request_i, flit_i, ready_i and the registered state.
REQ-016 A transfer on VC v occurs when valid_o[v] and ready_i[v] are both high; read_o SHALL pulse for exactly the source (port, vc) of that transfer and for no other.
REQ-017 Invariants: at most one valid_o bit set; at most one read_o bit set; valid_o never set for a VC whose ready_i is low.
REQ-018 Each VC SHALL hold per-VC state IDLE or LOCKED, a locked port index, and a one-hot round-robin last-grant vector over ports.
REQ-019 The port candidate of VC v in IDLE SHALL be the first requesting port searched cyclically starting after its last-grant port; in LOCKED it SHALL be the locked port, and only if that port requests.
REQ-020 VC v is eligible when it has a candidate and ready_i[v] is high.
REQ-021 With vc_lock_packet=0, the VC SHALL be chosen round-robin among eligible VCs, starting after the last VC that transferred.
REQ-022 With vc_lock_packet=1, while a link owner VC is mid-packet, only that VC is considered; other VCs are not granted even if eligible.
REQ-023 On a transfer from IDLE VC v: a HEADER flit sets v to LOCKED on that port; SINGLE, LAST or PAYLOAD leave v IDLE. The port last-grant of v updates to the granted port.
REQ-024 On a transfer from LOCKED VC v: a LAST or SINGLE flit returns v to IDLE; HEADER or PAYLOAD keeps it LOCKED.
REQ-025 A locked VC whose port deasserts request or whose ready_i is low SHALL stall without releasing the lock.
REQ-026 No transfer in a cycle SHALL leave all pointers and states unchanged.
REQ-027 Arbitration pointers SHALL advance only on a transfer, never on requests alone.

Reset
REQ-028 While rst_n is low: all VCs are IDLE; port last-grant = port ports-1 and VC last-grant = vc vchannels-1, so index 0 wins first; there is no link owner.
REQ-029 Reset assertion mid-packet SHALL drop all locks immediately; outputs follow REQ-015 from the reset state.

Verification
REQ-030 After reset, with ports=5 and vchannels=2, set request_i of ports 0, 2 and 3 on VC0 with SINGLE flits and ready_i=2'b01 -> grants go to ports 0, 2, 3, 0 on consecutive cycles, with valid_o=2'b01 each cycle.
REQ-031 Port 1 on VC0 sends HEADER, PAYLOAD, LAST while port 4 also requests on VC0 -> port 1 is granted for all 3 flits, then port 4.
REQ-032 With vc_lock_packet=0, VC0 and VC1 each send a 3-flit packet with both ready -> valid_o alternates 01, 10, 01, 10, 01, 10.
REQ-033 Same stimulus with vc_lock_packet=1 -> valid_o is 01, 01, 01, 10, 10, 10.
REQ-034 Port 2 on VC1 is locked after its HEADER; drop ready_i[1] for 3 cycles -> valid_o and read_o are 0 during those cycles, then the PAYLOAD comes from port 2 with no other port interleaved.
REQ-035 Pulse rst_n low after a HEADER transfer -> the next grant follows the reset priority (port 0 first), and read_o is never high for two bits in any cycle.
